// File: rtl/mux_nch_arb.sv
// +-----------------------------------------------------------------------------+
// | mux_nch_arb : N-channel valid/ready mux, select or round-robin, 1-entry reg |
// | Optional: MUX_NCH_ARB_PARITY_EN adds registered parity_o = ^out_data_o      |
// | Revision    : 1.0                                                           |
// +-----------------------------------------------------------------------------+
`default_nettype none

module mux_nch_arb #(
  parameter  int N_CH  = 4,
  parameter  int WIDTH = 8,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    mode_i,
  input  logic [SEL_W-1:0]        sel_i,
  input  logic [N_CH-1:0]         in_valid_i,
  output logic [N_CH-1:0]         in_ready_o,
  input  logic [N_CH*WIDTH-1:0]   in_data_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [WIDTH-1:0]        out_data_o,
  output logic [SEL_W-1:0]        out_ch_o
`ifdef MUX_NCH_ARB_PARITY_EN
  ,
  output logic                    parity_o
`endif
);

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  logic             load_en;
  logic             granted;
  logic [SEL_W-1:0] grant;
  logic [SEL_W-1:0] cand;
  logic [SEL_W-1:0] rr_ptr;
  logic [WIDTH-1:0] grant_data;

  // Channel index base+off folded back into 0..N_CH-1.
  function automatic logic [SEL_W-1:0] wrap_add(input logic [SEL_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= N_CH) sum = sum - N_CH;
    return SEL_W'(sum);
  endfunction

  assign load_en = !out_valid_o || out_ready_i;

  always_comb begin
    granted = 1'b0;
    grant   = '0;
    cand    = '0;
    if (mode_i == MODE_RR) begin
      for (int off = 0; off < N_CH; off++) begin
        cand = wrap_add(rr_ptr, off);
        if (!granted && in_valid_i[cand]) begin
          granted = 1'b1;
          grant   = cand;
        end
      end
    end else begin
      // Only the selected channel's valid is looked at; out-of-range sel never matches.
      for (int k = 0; k < N_CH; k++) begin
        if (sel_i == SEL_W'(k) && in_valid_i[k]) begin
          granted = 1'b1;
          grant   = SEL_W'(k);
        end
      end
    end
  end

  always_comb begin
    in_ready_o = '0;
    if (rst_i && load_en && granted) in_ready_o[grant] = 1'b1;
  end

  assign grant_data = in_data_i[grant*WIDTH +: WIDTH];

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_ch_o    <= '0;
      rr_ptr      <= '0;
`ifdef MUX_NCH_ARB_PARITY_EN
      parity_o    <= 1'b0;
`endif
    end else if (load_en) begin
      if (granted) begin
        out_valid_o <= 1'b1;
        out_data_o  <= grant_data;
        out_ch_o    <= grant;
`ifdef MUX_NCH_ARB_PARITY_EN
        parity_o    <= ^grant_data;
`endif
        if (mode_i == MODE_RR)
          rr_ptr <= (grant == SEL_W'(N_CH - 1)) ? '0 : grant + 1'b1;
      end else begin
        out_valid_o <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mux_nch_arb.sv
// Bench for mux_nch_arb: directed scenarios plus randomized traffic against a behavioural model.
`default_nettype none

module tb_mux_nch_arb;

  localparam int N = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          mode;
  logic [1:0]    sel;
  logic [N-1:0]  in_valid;
  logic [N-1:0]  in_ready;
  logic [N*W-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [1:0]    out_ch;

  logic          mode3;
  logic [1:0]    sel3;
  logic [2:0]    valid3;
  logic [2:0]    ready3;
  logic [23:0]   data3;
  logic          out_valid3;
  logic          out_ready3;
  logic [W-1:0]  out_data3;
  logic [1:0]    out_ch3;
`ifdef MUX_NCH_ARB_PARITY_EN
  logic          parity;
  logic          parity3;
`endif

  mux_nch_arb #(.N_CH(4), .WIDTH(8)) dut (
    .clk_i(clk), .rst_i(rst), .mode_i(mode), .sel_i(sel),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_data_o(out_data), .out_ch_o(out_ch)
`ifdef MUX_NCH_ARB_PARITY_EN
    , .parity_o(parity)
`endif
  );

  mux_nch_arb #(.N_CH(3), .WIDTH(8)) dut3 (
    .clk_i(clk), .rst_i(rst), .mode_i(mode3), .sel_i(sel3),
    .in_valid_i(valid3), .in_ready_o(ready3), .in_data_i(data3),
    .out_valid_o(out_valid3), .out_ready_i(out_ready3),
    .out_data_o(out_data3), .out_ch_o(out_ch3)
`ifdef MUX_NCH_ARB_PARITY_EN
    , .parity_o(parity3)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: contents of the output slot and the round-robin start point.
  logic         m_valid = 1'b0;
  logic [W-1:0] m_data  = '0;
  logic [1:0]   m_ch    = '0;
  int           m_ptr   = 0;
  int           g_exp;
  logic [N-1:0] exp_ready;

  // Winner: selected channel if valid, or the valid channel closest after m_ptr.
  function automatic int ref_grant();
    int best, bestd, d;
    if (!mode) return (int'(sel) < N && in_valid[sel]) ? int'(sel) : -1;
    best = -1;
    bestd = N;
    for (int k = 0; k < N; k++) begin
      if (in_valid[k]) begin
        d = (k - m_ptr + N) % N;
        if (d < bestd) begin
          bestd = d;
          best = k;
        end
      end
    end
    return best;
  endfunction

  function automatic void predict();
    g_exp = ref_grant();
    exp_ready = (rst && (!m_valid || out_ready) && g_exp >= 0) ? (4'b0001 << g_exp) : 4'b0000;
  endfunction

  function automatic void model_edge();
    if (!rst) begin
      m_valid = 1'b0; m_data = '0; m_ch = '0; m_ptr = 0;
    end else if (!m_valid || out_ready) begin
      if (g_exp >= 0) begin
        m_data  = in_data[g_exp*W +: W];
        m_ch    = 2'(g_exp);
        m_valid = 1'b1;
        if (mode) m_ptr = (g_exp + 1) % N;
      end else begin
        m_valid = 1'b0;
      end
    end
  endfunction

  task automatic test_reset();
    rst = 1'b0; mode = 1'b0; sel = 2'd0; in_valid = '1; in_data = $urandom; out_ready = 1'b1;
    mode3 = 1'b0; sel3 = 2'd0; valid3 = '1; data3 = 24'($urandom); out_ready3 = 1'b1;
    predict();
    model_edge();
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (in_ready !== 4'b0000) begin
      errors++; $display("FAIL reset_ready got=%b exp=0000", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ch !== 2'd0) begin
      errors++; $display("FAIL reset_out got v=%b d=%h ch=%0d exp v=0 d=00 ch=0", out_valid, out_data, out_ch);
    end
    checks++;
    if (ready3 !== 3'b000 || out_valid3 !== 1'b0) begin
      errors++; $display("FAIL reset_n3 got rdy=%b v=%b exp rdy=000 v=0", ready3, out_valid3);
    end
    rst = 1'b1;
    valid3 = '0;
  endtask

  task automatic test_sel();
    mode = 1'b0; sel = 2'd2; out_ready = 1'b1;
    in_valid = 4'b0100 | (4'($urandom) & 4'b1011);
    in_data = $urandom;
    in_data[23:16] = 8'hA5;
    #1;
    predict();
    checks++;
    if (in_ready !== 4'b0100) begin
      errors++; $display("FAIL sel_ready got=%b exp=0100", in_ready);
    end
    checks++;
    if ({in_ready, out_valid, out_data, out_ch} !== {exp_ready, m_valid, m_data, m_ch}) begin
      errors++; $display("FAIL model_sel got rdy=%b v=%b d=%h ch=%0d exp rdy=%b v=%b d=%h ch=%0d",
                         in_ready, out_valid, out_data, out_ch, exp_ready, m_valid, m_data, m_ch);
    end
    model_edge();
    @(negedge clk);
    in_valid = '0;
    #1;
    predict();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_ch !== 2'd2) begin
      errors++; $display("FAIL sel_out got v=%b d=%h ch=%0d exp v=1 d=a5 ch=2", out_valid, out_data, out_ch);
    end
    model_edge();
    @(negedge clk);
  endtask

  task automatic test_rr_all();
    mode = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      in_valid = '1;
      in_data = $urandom;
      #1;
      predict();
      if (i > 0) begin
        checks++;
        if (out_valid !== 1'b1 || out_ch !== 2'(i - 1)) begin
          errors++; $display("FAIL rr_seq word=%0d got v=%b ch=%0d exp v=1 ch=%0d", i - 1, out_valid, out_ch, (i - 1) % N);
        end
      end
      checks++;
      if ({in_ready, out_valid, out_data, out_ch} !== {exp_ready, m_valid, m_data, m_ch}) begin
        errors++; $display("FAIL model_rr got rdy=%b v=%b d=%h ch=%0d exp rdy=%b v=%b d=%h ch=%0d",
                           in_ready, out_valid, out_data, out_ch, exp_ready, m_valid, m_data, m_ch);
      end
      model_edge();
      @(negedge clk);
    end
  endtask

  task automatic test_rr_ptr();
    logic [N-1:0] vals [4];
    logic [N-1:0] rdys [4];
    vals = '{4'b0010, 4'b1010, 4'b1010, 4'b0000};
    rdys = '{4'b0010, 4'b1000, 4'b0010, 4'b0000};
    mode = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = vals[i];
      in_data = $urandom;
      #1;
      predict();
      checks++;
      if (in_ready !== rdys[i]) begin
        errors++; $display("FAIL rr_ptr_ready step=%0d got=%b exp=%b", i, in_ready, rdys[i]);
      end
      if (i >= 2) begin
        checks++;
        if (out_ch !== ((i == 2) ? 2'd3 : 2'd1)) begin
          errors++; $display("FAIL rr_ptr_order step=%0d got ch=%0d exp ch=%0d", i, out_ch, (i == 2) ? 3 : 1);
        end
      end
      model_edge();
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] d0, d1;
    mode = 1'b0; sel = 2'd1; out_ready = 1'b1;
    d0 = 8'($urandom);
    in_valid = 4'b0010;
    in_data = $urandom;
    in_data[15:8] = d0;
    #1;
    predict();
    model_edge();
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = '1;
      in_data = $urandom;
      #1;
      predict();
      checks++;
      if (in_ready !== 4'b0000 || out_valid !== 1'b1 || out_data !== d0 || out_ch !== 2'd1) begin
        errors++; $display("FAIL bp_hold cyc=%0d got rdy=%b v=%b d=%h ch=%0d exp rdy=0000 v=1 d=%h ch=1",
                           i, in_ready, out_valid, out_data, out_ch, d0);
      end
      model_edge();
      @(negedge clk);
    end
    out_ready = 1'b1;
    d1 = d0 ^ 8'h5A;
    in_valid = '1;
    in_data = $urandom;
    in_data[15:8] = d1;
    #1;
    predict();
    checks++;
    if (in_ready !== 4'b0010) begin
      errors++; $display("FAIL bp_release_ready got=%b exp=0010", in_ready);
    end
    model_edge();
    @(negedge clk);
    in_valid = '0;
    #1;
    predict();
    checks++;
    if (out_valid !== 1'b1 || out_data !== d1 || out_ch !== 2'd1) begin
      errors++; $display("FAIL bp_release_out got v=%b d=%h ch=%0d exp v=1 d=%h ch=1", out_valid, out_data, out_ch, d1);
    end
    model_edge();
    @(negedge clk);
  endtask

  task automatic test_out_of_range();
    mode3 = 1'b0; sel3 = 2'd0; valid3 = 3'b111; out_ready3 = 1'b1;
    data3 = {8'h11, 8'h22, 8'h07};
    #1;
    checks++;
    if (ready3 !== 3'b001) begin
      errors++; $display("FAIL oor_load_ready got=%b exp=001", ready3);
    end
    @(negedge clk);
    sel3 = 2'd3;
    #1;
    checks++;
    if (ready3 !== 3'b000 || out_valid3 !== 1'b1 || out_data3 !== 8'h07 || out_ch3 !== 2'd0) begin
      errors++; $display("FAIL oor_nogrant got rdy=%b v=%b d=%h ch=%0d exp rdy=000 v=1 d=07 ch=0",
                         ready3, out_valid3, out_data3, out_ch3);
    end
`ifdef MUX_NCH_ARB_PARITY_EN
    checks++;
    if (parity3 !== 1'b1) begin
      errors++; $display("FAIL oor_parity got=%b exp=1", parity3);
    end
`endif
    @(negedge clk);
    #1;
    checks++;
    if (out_valid3 !== 1'b0 || out_data3 !== 8'h07 || out_ch3 !== 2'd0) begin
      errors++; $display("FAIL oor_drop got v=%b d=%h ch=%0d exp v=0 d=07 ch=0", out_valid3, out_data3, out_ch3);
    end
    valid3 = '0;
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 31) != 0);
      mode      = 1'($urandom);
      sel       = 2'($urandom);
      in_valid  = 4'($urandom);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      predict();
      checks++;
      if ({in_ready, out_valid, out_data, out_ch} !== {exp_ready, m_valid, m_data, m_ch}) begin
        errors++; $display("FAIL model_rand cyc=%0d got rdy=%b v=%b d=%h ch=%0d exp rdy=%b v=%b d=%h ch=%0d",
                           i, in_ready, out_valid, out_data, out_ch, exp_ready, m_valid, m_data, m_ch);
      end
`ifdef MUX_NCH_ARB_PARITY_EN
      checks++;
      if (parity !== ^m_data) begin
        errors++; $display("FAIL parity_rand cyc=%0d got=%b exp=%b", i, parity, ^m_data);
      end
`endif
      model_edge();
      @(negedge clk);
    end
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_sel();
    test_rr_all();
    test_rr_ptr();
    test_backpressure();
    test_out_of_range();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
